// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write tracker: one busy bit per register, set beats clear on a
// same-address collision, bit 0 never busy.
module regfile_scoreboard #(
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             set,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr,
  input  logic [AW-1:0]    clr_addr,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    if (en) begin
      // clear first so a same-cycle set on the same entry overrides it
      if (clr && clr_addr != '0) busy_nxt[clr_addr] = 1'b0;
      if (set && set_addr != '0) busy_nxt[set_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) busy <= '0;
    else         busy <= busy_nxt;
  end

endmodule

// File: rtl/regfile_mp.sv
// Register file with NRD combinational read ports, one write port, a
// post-reset clear sequence and a pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to readers.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = NRD_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              resetn,
  output logic              init_done,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_addr
);

  state_t          state, state_nxt;
  logic [AW-1:0]   cnt, cnt_nxt;
  logic [AW-1:0]   init_addr;
  logic            run, init_wr;
  logic [XLEN-1:0] mem [NREGS];
  logic [NREGS-1:0] busy;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt walks 0..NREGS-2 while entry cnt+1 is cleared; entry 0 is never stored
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_INIT: begin
        cnt_nxt = cnt + AW'(1);
        if (cnt == AW'(NREGS - 2)) state_nxt = ST_RUN;
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  assign run       = resetn && (state == ST_RUN);
  assign init_wr   = resetn && (state == ST_INIT);
  assign init_addr = cnt + AW'(1);
  assign init_done = run;

  always_ff @(posedge clk) begin
    if (init_wr)                       mem[init_addr] <= '0;
    else if (run && we && waddr != '0) mem[waddr]     <= wdata;
  end

  regfile_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk      (clk),
    .resetn   (resetn),
    .en       (run),
    .set      (sb_set),
    .set_addr (sb_addr),
    .clr      (we),
    .clr_addr (waddr),
    .busy     (busy)
  );

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            rb;

    assign ra = raddr[g*AW +: AW];

    always_comb begin
      rd = '0;
      rb = 1'b0;
      if (run && ra != '0) begin
        rd = mem[ra];
        rb = busy[ra];
`ifdef REGFILE_BYPASS_EN
        if (we && waddr == ra) begin
          rd = wdata;
          rb = 1'b0;
        end
`endif
      end
    end

    assign rdata[g*XLEN +: XLEN] = rd;
    assign rbusy[g]              = rb;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 32x32x2 instance plus a 16x64x3 sweep.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [9:0]  raddr = '0;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        init_done;
  logic        sb_set = 1'b0;
  logic [4:0]  sb_addr = '0;

  logic         resetn2 = 1'b0;
  logic         we2 = 1'b0;
  logic [3:0]   waddr2 = '0;
  logic [63:0]  wdata2 = '0;
  logic [11:0]  raddr2 = '0;
  logic [191:0] rdata2;
  logic [2:0]   rbusy2;
  logic         init_done2;
  logic         sb_set2 = 1'b0;
  logic [3:0]   sb_addr2 = '0;

  int checks = 0;
  int errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .resetn(resetn), .init_done(init_done), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3)) dut2 (
    .clk(clk), .resetn(resetn2), .init_done(init_done2), .we(we2), .waddr(waddr2),
    .wdata(wdata2), .raddr(raddr2), .rdata(rdata2), .rbusy(rbusy2),
    .sb_set(sb_set2), .sb_addr(sb_addr2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (init_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_init2(output int n);
    n = 0;
    while (init_done2 !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    #2;
    checks++;
    if ({init_done, rdata, rbusy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got done=%b rdata=%h rbusy=%b, want all 0", init_done, rdata, rbusy);
    end
    tick();
    resetn = 1'b1;
    wait_init(n);
    checks++;
    if (n !== 31) begin
      errors++;
      $display("FAIL init_cycles: got %0d, want 31", n);
    end
    for (int a = 1; a < 32; a++) begin
      raddr = {5'(a), 5'(a)};
      #1;
      checks++;
      if (rdata !== 64'h0 || rbusy !== 2'b00) begin
        errors++;
        $display("FAIL cleared_x%0d: got rdata=%h rbusy=%b, want 0", a, rdata, rbusy);
      end
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr = {5'd5, 5'd5};
    #1;
    checks++;
    if (rdata[31:0] !== (BYP ? 32'hDEADBEEF : 32'h0)) begin
      errors++;
      $display("FAIL wr_cycle_x5: got %h, want %h", rdata[31:0], BYP ? 32'hDEADBEEF : 32'h0);
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rdata !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL readback_x5: got %h, want deadbeefdeadbeef", rdata);
    end
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234; raddr = {5'd5, 5'd0};
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rdata !== {32'hDEADBEEF, 32'h0}) begin
      errors++;
      $display("FAIL x0_write: got %h, want deadbeef00000000", rdata);
    end
  endtask

  task automatic test_scoreboard();
    sb_set = 1'b1; sb_addr = 5'd7; raddr = {5'd7, 5'd7};
    #1;
    checks++;
    if (rbusy !== 2'b00) begin
      errors++;
      $display("FAIL sb_before_edge: got %b, want 00", rbusy);
    end
    tick();
    sb_set = 1'b0;
    #1;
    checks++;
    if (rbusy !== 2'b11) begin
      errors++;
      $display("FAIL sb_set_x7: got %b, want 11", rbusy);
    end
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5;
    #1;
    checks++;
    if (rbusy[0] !== !BYP) begin
      errors++;
      $display("FAIL sb_wr_cycle_x7: got %b, want %b", rbusy[0], !BYP);
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rbusy !== 2'b00 || rdata[31:0] !== 32'hA5) begin
      errors++;
      $display("FAIL sb_clear_x7: got rbusy=%b rdata=%h, want 00 a5", rbusy, rdata[31:0]);
    end
    sb_set = 1'b1; sb_addr = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'h99; raddr = {5'd9, 5'd9};
    tick();
    sb_set = 1'b0; we = 1'b0;
    #1;
    checks++;
    if (rbusy !== 2'b11 || rdata[63:32] !== 32'h99) begin
      errors++;
      $display("FAIL sb_set_wins_x9: got rbusy=%b rdata=%h, want 11 99", rbusy, rdata[63:32]);
    end
    sb_set = 1'b1; sb_addr = 5'd0; raddr = {5'd9, 5'd0};
    tick();
    sb_set = 1'b0;
    #1;
    checks++;
    if (rbusy !== 2'b10 || rdata[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL sb_x0: got rbusy=%b rdata=%h, want 10 0", rbusy, rdata[31:0]);
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd3; wdata = 32'h55AA; raddr = {5'd0, 5'd3};
    #1;
    checks++;
    if (rdata[31:0] !== (BYP ? 32'h55AA : 32'h0)) begin
      errors++;
      $display("FAIL bypass_x3: got %h, want %h", rdata[31:0], BYP ? 32'h55AA : 32'h0);
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rdata[31:0] !== 32'h55AA) begin
      errors++;
      $display("FAIL after_write_x3: got %h, want 55aa", rdata[31:0]);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    we = 1'b1; waddr = 5'd4; wdata = 32'h44; sb_set = 1'b1; sb_addr = 5'd4; raddr = {5'd5, 5'd4};
    tick();
    we = 1'b0; sb_set = 1'b0;
    #1;
    checks++;
    if (rbusy[0] !== 1'b1 || rdata[31:0] !== 32'h44) begin
      errors++;
      $display("FAIL x4_busy: got rbusy=%b rdata=%h, want 1 44", rbusy[0], rdata[31:0]);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({init_done, rdata, rbusy} !== '0) begin
      errors++;
      $display("FAIL reset_low_outputs: got done=%b rdata=%h rbusy=%b, want 0", init_done, rdata, rbusy);
    end
    tick();
    resetn = 1'b1;
    we = 1'b1; waddr = 5'd2; wdata = 32'hFFFF_FFFF; sb_set = 1'b1; sb_addr = 5'd2;
    #1;
    checks++;
    if ({init_done, rdata, rbusy} !== '0) begin
      errors++;
      $display("FAIL init_outputs: got done=%b rdata=%h rbusy=%b, want 0", init_done, rdata, rbusy);
    end
    repeat (10) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checks++;
    if (init_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_init_reset_done: got %b, want 0", init_done);
    end
    wait_init(n);
    we = 1'b0; sb_set = 1'b0;
    checks++;
    if (n !== 31) begin
      errors++;
      $display("FAIL mid_init_cycles: got %0d, want 31", n);
    end
    raddr = {5'd2, 5'd4};
    #1;
    checks++;
    if (rdata !== 64'h0 || rbusy !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_x2_x4: got rdata=%h rbusy=%b, want 0 00", rdata, rbusy);
    end
  endtask

  task automatic test_sweep();
    int n;
    resetn2 = 1'b0;
    tick();
    resetn2 = 1'b1;
    wait_init2(n);
    checks++;
    if (n !== 15) begin
      errors++;
      $display("FAIL sweep_init_cycles: got %0d, want 15", n);
    end
    we2 = 1'b1; waddr2 = 4'd1; wdata2 = 64'h0123_4567_89AB_CDEF; sb_set2 = 1'b1; sb_addr2 = 4'd15;
    tick();
    sb_set2 = 1'b0; waddr2 = 4'd2; wdata2 = 64'hFEDC_BA98_7654_3210;
    tick();
    waddr2 = 4'd15; wdata2 = 64'h8000_0000_0000_0001; sb_set2 = 1'b1;
    tick();
    we2 = 1'b0; sb_set2 = 1'b0;
    raddr2 = {4'd15, 4'd2, 4'd1};
    #1;
    checks++;
    if (rdata2 !== {64'h8000_0000_0000_0001, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF}) begin
      errors++;
      $display("FAIL sweep_read3: got %h", rdata2);
    end
    checks++;
    if (rbusy2 !== 3'b100) begin
      errors++;
      $display("FAIL sweep_busy: got %b, want 100", rbusy2);
    end
    raddr2 = {4'd1, 4'd15, 4'd0};
    #1;
    checks++;
    if (rdata2 !== {64'h0123_4567_89AB_CDEF, 64'h8000_0000_0000_0001, 64'h0}) begin
      errors++;
      $display("FAIL sweep_permute: got %h", rdata2);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_bypass();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; power of two, 2..64; AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports, 1..4.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-006 SHALL have port init_done  output  1  high once the clear sequence has finished.
REQ-007 SHALL have port we  input  1  write enable.
REQ-008 SHALL have port waddr  input  AW  write address.
REQ-009 SHALL have port wdata  input  XLEN  write data.
REQ-010 SHALL have port raddr  input  NRD*AW  packed read addresses; port i at bits [i*AW +: AW].
REQ-011 SHALL have port rdata  output  NRD*XLEN  packed read data, packed the same way.
REQ-012 SHALL have port rbusy  output  NRD  per-port pending-write flag for raddr[i].
REQ-013 SHALL have port sb_set  input  1  mark sb_addr as having an outstanding long-latency write.
REQ-014 SHALL have port sb_addr  input  AW  scoreboard set address.

Function
REQ-015 SHALL implement a two-state FSM, INIT and RUN.
REQ-016 In INIT, SHALL write zero to one entry per cycle, addresses 1..NREGS-1, using an AW-bit counter; SHALL move to RUN on the cycle after address NREGS-1 is written (NREGS-1 cycles in INIT); RUN is absorbing.
REQ-017 SHALL hold init_done = 0 in INIT and 1 in RUN.
REQ-018 In INIT, SHALL ignore we and sb_set, drive all rdata to 0 and all rbusy to 0.
REQ-019 In RUN, SHALL write wdata to entry waddr on the clock edge when we=1 and waddr!=0.
REQ-020 SHALL return rdata[i] combinationally (zero-cycle latency) from entry raddr[i].
REQ-021 SHALL return rdata[i] = 0 and rbusy[i] = 0 whenever raddr[i]=0, regardless of writes, bypass or scoreboard.
REQ-022 SHALL keep an NREGS-bit busy vector; bit 0 is constant 0.
REQ-023 In RUN, sb_set=1 with sb_addr!=0 SHALL set busy[sb_addr]; we=1 with waddr!=0 SHALL clear busy[waddr].
REQ-024 On a simultaneous set and clear of the same address, the set SHALL win: the bit stays 1.
REQ-025 SHALL drive rbusy[i] = busy[raddr[i]], combinational.
REQ-026 Multiple read ports on the same address SHALL return identical data and busy values.

Reset
REQ-027 resetn=0 at a rising edge SHALL put the FSM in INIT, zero the counter and clear the busy vector, at any time, including mid-INIT.
REQ-028 While resetn=0, SHALL drive init_done = 0, all rdata = 0 and all rbusy = 0, and SHALL write no array entry.
REQ-029 The array SHALL have no reset of its own; only the INIT sequence clears it.

Configuration
REQ-030 With REGFILE_BYPASS_EN defined, in RUN with we=1 and waddr==raddr[i]!=0, SHALL drive rdata[i] = wdata and rbusy[i] = 0 in the same cycle (write-through forwarding).
REQ-031 Without REGFILE_BYPASS_EN, SHALL return the pre-write array contents and the current busy bit in the write cycle; the new value appears from the next cycle.

Structure
REQ-032 SHALL place in package regfile_pkg: the FSM state typedef (INIT, RUN) and the default parameter constants (XLEN, NREGS, NRD).
REQ-033 SHALL implement the busy vector, with its set/clear priority, in one sub-module, regfile_scoreboard.
REQ-034 SHALL implement the array and read muxes inline, with NRD read muxes generated by a loop.

Verification
REQ-035 Reset to ready: pulse resetn low for 1 cycle -> init_done rises exactly 31 cycles later (NREGS=32); every read returns 0 after that.
REQ-036 Write and read back: write 0xDEADBEEF to x5, then read x5 on port 0 and port 1 the next cycle -> both return 0xDEADBEEF; writing 0x1234 to x0 -> x0 still reads 0.
REQ-037 Scoreboard: sb_set on x7 -> rbusy=1 for x7 next cycle; write x7=0xA5 -> rbusy=0; same-cycle sb_set and write on x9 -> busy[9] stays 1.
REQ-038 Bypass: write x3=0x55AA while reading x3 -> returns 0x55AA in the same cycle with REGFILE_BYPASS_EN defined, and the old value without it.
REQ-039 Reset mid-operation: assert resetn low during INIT at counter=10, and again in RUN with x4 busy -> counter restarts at 0, busy cleared, init_done low, full 31-cycle clear repeats.
REQ-040 Parameter sweep: NREGS=16, XLEN=64, NRD=3 -> INIT lasts 15 cycles, all 3 ports read independently, 64-bit data intact.
